// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-locked arbiter sharing the FIFO write port
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          w_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          store,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] burst_cnt;

    logic             pick_valid;
    logic [PTR_W-1:0] pick;
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic             burst_done;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] x);
        if (int'(x) == NUM_REQ - 1) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin : pick_scan
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[PTR_W'(idx)]) begin
                pick_valid = 1'b1;
                pick       = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = owner;
        if (!rst && !fifo_full) begin
            if (state == ST_IDLE) begin
                grant_valid = pick_valid;
                grant_idx   = pick;
            end else begin
                grant_valid = req[owner];
                grant_idx   = owner;
            end
        end
    end

    assign ack        = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    assign store      = grant_valid;
    assign wr_data    = grant_valid ? req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign busy       = (state == ST_LOCK);
    assign burst_done = req_last[owner] || (burst_cnt + 1'b1 == CNT_W'(MAX_BURST));

    always_ff @(posedge w_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner <= pick;
                        if (req_last[pick] || MAX_BURST == 1) begin
                            rr_ptr <= wrap_inc(pick);
                        end else begin
                            state     <= ST_LOCK;
                            burst_cnt <= CNT_W'(1);
                        end
                    end
                end
                ST_LOCK: begin
                    // A full FIFO freezes the burst without spending its budget.
                    if (!fifo_full) begin
                        if (req[owner]) begin
                            if (burst_done) begin
                                state     <= ST_IDLE;
                                rr_ptr    <= wrap_inc(owner);
                                burst_cnt <= '0;
                            end else begin
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                        end else begin
                            state     <= ST_IDLE;
                            rr_ptr    <= wrap_inc(owner);
                            burst_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed and randomized checks of fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int MAXB = 4;

    logic        w_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        fifo_full;
    logic [3:0]  ack;
    logic        store;
    logic [7:0]  wr_data;
    logic [1:0]  owner;
    logic        busy;

    logic [2:0]  req3;
    logic [23:0] req3_data;
    logic [2:0]  last3;
    logic        full3;
    logic [2:0]  ack3;
    logic        store3;
    logic [7:0]  wr3;
    logic [1:0]  owner3;
    logic        busy3;

    int errors = 0;
    int checks = 0;

    always #5 w_clk = ~w_clk;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
        .w_clk(w_clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .fifo_full(fifo_full), .store(store), .wr_data(wr_data),
        .owner(owner), .busy(busy)
    );

    fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut3 (
        .w_clk(w_clk), .rst(rst), .req(req3), .req_data(req3_data), .req_last(last3),
        .ack(ack3), .fifo_full(full3), .store(store3), .wr_data(wr3),
        .owner(owner3), .busy(busy3)
    );

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1; req = '0; req_last = '0; fifo_full = 1'b0;
        req3 = '0; last3 = '0; full3 = 1'b0;
        req_data = $urandom; req3_data = 24'($urandom);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'hF; req_last = 4'h0; fifo_full = 1'b0;
        req3 = 3'b111; req_data = $urandom;
        tick();
        @(negedge w_clk);
        checks++;
        if ({ack, store, wr_data, busy, owner} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b store=%b wr_data=%h busy=%b owner=%0d, want all 0",
                     ack, store, wr_data, busy, owner);
        end
        checks++;
        if ({ack3, store3, busy3, owner3} !== 7'h0) begin
            errors++;
            $display("FAIL reset_outputs3: got ack=%b store=%b busy=%b owner=%0d, want all 0",
                     ack3, store3, busy3, owner3);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [3:0] ea;
        logic       eb;
        int         g;
        reset_dut();
        req = 4'hF; req_last = 4'h0;
        for (int c = 0; c < 20; c++) begin
            g  = (c / 4) % 4;
            ea = 4'(1 << g);
            eb = (c % 4) != 0;
            @(negedge w_clk);
            checks++;
            if ({ack, store, busy, wr_data} !== {ea, 1'b1, eb, req_data[g*8 +: 8]}) begin
                errors++;
                $display("FAIL round_robin c=%0d: got ack=%b store=%b busy=%b wr=%h, want ack=%b store=1 busy=%b wr=%h",
                         c, ack, store, busy, wr_data, ea, eb, req_data[g*8 +: 8]);
            end
            tick();
        end
    endtask

    task automatic test_alternate;
        logic [3:0] ea;
        reset_dut();
        req = 4'b0101; req_last = 4'hF;
        for (int c = 0; c < 8; c++) begin
            ea = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            @(negedge w_clk);
            checks++;
            if ({ack, store, busy} !== {ea, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL alternate c=%0d: got ack=%b store=%b busy=%b, want ack=%b store=1 busy=0",
                         c, ack, store, busy, ea);
            end
            tick();
        end
    endtask

    task automatic test_stall;
        logic [3:0] seq [3];
        seq[0] = 4'b0100; seq[1] = 4'b0100; seq[2] = 4'b1000;
        reset_dut();
        req = 4'b0100; req_last = 4'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge w_clk);
            checks++;
            if ({ack, busy} !== {4'b0100, c == 1}) begin
                errors++;
                $display("FAIL stall_prefix c=%0d: got ack=%b busy=%b, want ack=0100 busy=%0d", c, ack, busy, c == 1);
            end
            tick();
        end
        req = 4'hF; fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge w_clk);
            checks++;
            if ({ack, store, owner, busy} !== {4'b0000, 1'b0, 2'd2, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold c=%0d: got ack=%b store=%b owner=%0d busy=%b, want 0000 0 2 1",
                         c, ack, store, owner, busy);
            end
            tick();
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge w_clk);
            checks++;
            if ({ack, store} !== {seq[c], 1'b1}) begin
                errors++;
                $display("FAIL stall_resume c=%0d: got ack=%b store=%b, want ack=%b store=1", c, ack, store, seq[c]);
            end
            tick();
        end
    endtask

    task automatic test_early_release;
        reset_dut();
        req = 4'b1010; req_last = 4'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge w_clk);
            checks++;
            if (ack !== 4'b0010) begin
                errors++;
                $display("FAIL early_prefix c=%0d: got ack=%b, want 0010", c, ack);
            end
            tick();
        end
        req = 4'b1000;
        @(negedge w_clk);
        checks++;
        if ({ack, store, busy} !== {4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL early_bubble: got ack=%b store=%b busy=%b, want 0000 0 1", ack, store, busy);
        end
        tick();
        @(negedge w_clk);
        checks++;
        if ({ack, busy} !== {4'b1000, 1'b0}) begin
            errors++;
            $display("FAIL early_regrant: got ack=%b busy=%b, want 1000 0", ack, busy);
        end
        tick();
        @(negedge w_clk);
        checks++;
        if ({ack, owner, busy} !== {4'b1000, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL early_owner: got ack=%b owner=%0d busy=%b, want 1000 3 1", ack, owner, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        reset_dut();
        req = 4'b0011; req_last = 4'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge w_clk);
            checks++;
            if (ack !== 4'b0001) begin
                errors++;
                $display("FAIL midrst_prefix c=%0d: got ack=%b, want 0001", c, ack);
            end
            tick();
        end
        rst = 1'b1;
        @(negedge w_clk);
        checks++;
        if ({ack, store, wr_data} !== 13'h0) begin
            errors++;
            $display("FAIL midrst_cycle: got ack=%b store=%b wr=%h, want all 0", ack, store, wr_data);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge w_clk);
            checks++;
            if ({ack, busy} !== {(c < 4) ? 4'b0001 : 4'b0010, (c > 0 && c < 4)}) begin
                errors++;
                $display("FAIL midrst_restart c=%0d: got ack=%b busy=%b, want ack=%b busy=%0d",
                         c, ack, busy, (c < 4) ? 4'b0001 : 4'b0010, (c > 0 && c < 4));
            end
            tick();
        end
    endtask

    task automatic test_wrap3;
        logic [2:0] rq [4];
        logic [2:0] ea [4];
        int         gi [4];
        rq[0] = 3'b001; rq[1] = 3'b010; rq[2] = 3'b100; rq[3] = 3'b111;
        ea[0] = 3'b001; ea[1] = 3'b010; ea[2] = 3'b100; ea[3] = 3'b001;
        gi[0] = 0; gi[1] = 1; gi[2] = 2; gi[3] = 0;
        reset_dut();
        last3 = 3'b000;
        for (int c = 0; c < 4; c++) begin
            req3 = rq[c];
            @(negedge w_clk);
            checks++;
            if ({ack3, store3, busy3, wr3} !== {ea[c], 1'b1, 1'b0, req3_data[gi[c]*8 +: 8]}) begin
                errors++;
                $display("FAIL wrap3 c=%0d: got ack=%b store=%b busy=%b wr=%h, want ack=%b store=1 busy=0 wr=%h",
                         c, ack3, store3, busy3, wr3, ea[c], req3_data[gi[c]*8 +: 8]);
            end
            tick();
        end
        checks++;
        if (owner3 !== 2'd0) begin
            errors++;
            $display("FAIL wrap3_owner: got owner=%0d, want 0", owner3);
        end
        req3 = '0;
    endtask

    task automatic test_random;
        bit         r_act [4];
        logic [7:0] r_dat [4];
        bit         r_lst [4];
        bit         m_lock;
        int         m_owner, m_used, m_next, eg, idx;
        logic [15:0] exp_v;
        reset_dut();
        m_lock = 0; m_owner = 0; m_used = 0; m_next = 0;
        for (int i = 0; i < 4; i++) begin
            r_act[i] = 0; r_dat[i] = '0; r_lst[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            fifo_full = ($urandom % 4) == 0;
            for (int i = 0; i < 4; i++) begin
                req[i]           = r_act[i];
                req_data[i*8 +: 8] = r_dat[i];
                req_last[i]      = r_act[i] ? r_lst[i] : 1'($urandom);
            end
            @(negedge w_clk);
            eg = -1;
            if (!fifo_full) begin
                if (!m_lock) begin
                    for (int k = 0; k < 4; k++) begin
                        idx = (m_next + k) % 4;
                        if (r_act[idx] && eg < 0) eg = idx;
                    end
                end else if (r_act[m_owner]) begin
                    eg = m_owner;
                end
            end
            exp_v = {(eg >= 0) ? 4'(1 << eg) : 4'b0, eg >= 0,
                     (eg >= 0) ? r_dat[eg] : 8'h0, m_lock, 2'(m_owner)};
            checks++;
            if ({ack, store, wr_data, busy, owner} !== exp_v) begin
                errors++;
                $display("FAIL random c=%0d: got ack=%b store=%b wr=%h busy=%b owner=%0d, want {ack,store,wr,busy,owner}=%h",
                         c, ack, store, wr_data, busy, owner, exp_v);
            end
            if (!m_lock) begin
                if (eg >= 0) begin
                    m_owner = eg;
                    if (r_lst[eg]) m_next = (eg + 1) % 4;
                    else begin m_lock = 1; m_used = 1; end
                end
            end else if (!fifo_full) begin
                if (r_act[m_owner]) begin
                    m_used++;
                    if (r_lst[m_owner] || m_used == MAXB) begin
                        m_lock = 0; m_used = 0; m_next = (m_owner + 1) % 4;
                    end
                end else begin
                    m_lock = 0; m_used = 0; m_next = (m_owner + 1) % 4;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (eg == i) begin
                    r_act[i] = ($urandom % 4) != 0;
                end else if (!r_act[i]) begin
                    r_act[i] = ($urandom % 2) != 0;
                end else begin
                    continue;
                end
                r_dat[i] = 8'($urandom);
                r_lst[i] = ($urandom % 3) == 0;
            end
            tick();
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
        req3 = '0; req3_data = '0; last3 = '0; full3 = 1'b0;
        #1;
        test_reset();
        test_round_robin();
        test_alternate();
        test_stall();
        test_early_release();
        test_reset_mid_burst();
        test_wrap3();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
